// File: rtl/icache_pkg.sv
// icache_pkg: shared line geometry, address field positions and FSM state type
package icache_pkg;
    localparam int LINE_WORDS = 4;
    localparam int WORD_W     = 32;
    localparam int LINE_W     = LINE_WORDS * WORD_W;
    localparam int WSEL_LSB   = 2;
    localparam int WSEL_W     = 2;
    localparam int INDEX_LSB  = WSEL_LSB + WSEL_W;
    typedef enum logic [1:0] {IDLE, MISS, FILL} icache_state_t;
endpackage

// File: rtl/icache_data_array.sv
// icache_data_array: NUM_LINES x 128-bit line storage, one write port, combinational read
//   clk            : write clock
//   we/waddr/wdata : line write at rising edge
//   raddr/rdata    : combinational line read
module icache_data_array
    import icache_pkg::*;
#(
    parameter int NUM_LINES = 8,
    parameter int IW = $clog2(NUM_LINES)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IW-1:0]     waddr,
    input  logic [LINE_W-1:0] wdata,
    input  logic [IW-1:0]     raddr,
    output logic [LINE_W-1:0] rdata
);
    logic [LINE_W-1:0] mem [NUM_LINES];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];
endmodule

// File: rtl/icache.sv
// icache: direct-mapped instruction cache, 16-byte lines, blocking miss handling
//   clk, reset (async, active-low)
//   in_PC/in_read_enable/in_invalidate : fetch request and fence.i flush
//   out_instruction/out_valid/out_stall : fetch response
//   mem_req/mem_addr/mem_ready/mem_rdata : line-fill interface to main memory
//   out_hit_count/out_miss_count         : wrapping performance counters
module icache
    import icache_pkg::*;
#(
    parameter int NUM_LINES = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       in_PC,
    input  logic              in_read_enable,
    input  logic              in_invalidate,
    output logic [31:0]       out_instruction,
    output logic              out_valid,
    output logic              out_stall,
    output logic              mem_req,
    output logic [31:0]       mem_addr,
    input  logic              mem_ready,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic [31:0]       out_hit_count,
    output logic [31:0]       out_miss_count
);
    localparam int IW      = $clog2(NUM_LINES);
    localparam int TAG_LSB = INDEX_LSB + IW;
    localparam int TW      = 32 - TAG_LSB;

    icache_state_t        state;
    logic [31:WSEL_LSB]   miss_addr;
    logic [NUM_LINES-1:0] valid;
    logic [TW-1:0]        tags [NUM_LINES];
    logic [IW-1:0]        pc_idx, miss_idx, rd_idx;
    logic [WSEL_W-1:0]    wsel;
    logic [LINE_W-1:0]    rd_line;
    logic                 hit, miss, fill_we, unused;

    assign unused   = ^in_PC[WSEL_LSB-1:0];
    assign pc_idx   = in_PC[TAG_LSB-1:INDEX_LSB];
    assign miss_idx = miss_addr[TAG_LSB-1:INDEX_LSB];
    assign hit      = reset && state == IDLE && in_read_enable && valid[pc_idx]
                      && tags[pc_idx] == in_PC[31:TAG_LSB];
    assign miss     = reset && state == IDLE && in_read_enable && !hit;
    assign fill_we  = state == MISS && mem_ready;
    // The single read port serves the hit path in IDLE and the delivery in FILL
    assign rd_idx   = state == FILL ? miss_idx : pc_idx;
    assign wsel     = state == FILL ? miss_addr[INDEX_LSB-1:WSEL_LSB] : in_PC[INDEX_LSB-1:WSEL_LSB];

    assign out_valid       = hit || (reset && state == FILL);
    assign out_stall       = miss || (reset && state == MISS);
    assign out_instruction = out_valid ? rd_line[{wsel, 5'b0} +: 32] : '0;
    assign mem_req         = reset && state == MISS;
    assign mem_addr        = {miss_addr[31:INDEX_LSB], {INDEX_LSB{1'b0}}};

    icache_data_array #(.NUM_LINES(NUM_LINES), .IW(IW)) u_data (
        .clk   (clk),
        .we    (fill_we),
        .waddr (miss_idx),
        .wdata (mem_rdata),
        .raddr (rd_idx),
        .rdata (rd_line)
    );

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state          <= IDLE;
            miss_addr      <= '0;
            valid          <= '0;
            out_hit_count  <= '0;
            out_miss_count <= '0;
        end else begin
            state <= miss ? MISS : fill_we ? FILL : state == FILL ? IDLE : state;
            if (miss) miss_addr <= in_PC[31:WSEL_LSB];
            if (hit) out_hit_count <= out_hit_count + 32'd1;
            if (miss) out_miss_count <= out_miss_count + 32'd1;
            // A flush on the fill edge wins: the line lands but stays invalid
            if (in_invalidate) valid <= '0;
            else if (fill_we) valid[miss_idx] <= 1'b1;
        end

    always_ff @(posedge clk)
        if (fill_we) tags[miss_idx] <= miss_addr[31:TAG_LSB];
endmodule
